// File: rtl/bn_pkg.sv
// Shared types for the batch-norm parameter loader: RAM select codes, loader
// states and the packed {select, address} write-address helper.
package bn_pkg;

    localparam int RAM_SELECT_BITS = 2;

    typedef enum logic [RAM_SELECT_BITS-1:0] {
        BN_MEAN   = 2'd0,
        BN_VAR    = 2'd1,
        BN_SCALE  = 2'd2,
        BN_OFFSET = 2'd3
    } bn_ram_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bn_ld_state_e;

    // Select lands in the bits directly above the per-RAM address.
    function automatic logic [31:0] bn_pack_addr(input logic [RAM_SELECT_BITS-1:0] sel,
                                                 input logic [29:0] addr,
                                                 input int unsigned addr_bits);
        return (32'(sel) << addr_bits) | 32'(addr);
    endfunction

endpackage

// File: rtl/bn_addr_counter.sv
// Per-RAM address counter wrapping at INPUT_SIZE, carrying into the 2-bit
// RAM select counter; flags the final (offset RAM, last entry) position.
module bn_addr_counter
    import bn_pkg::*;
#(
    parameter int INPUT_SIZE = 1,
    parameter int ADDR_BITS  = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic                       clr_i,
    output logic [ADDR_BITS-1:0]       addr_o,
    output logic [RAM_SELECT_BITS-1:0] sel_o,
    output logic                       last_o
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(INPUT_SIZE - 1);

    logic [ADDR_BITS-1:0]       r_addr;
    logic [RAM_SELECT_BITS-1:0] r_sel;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_addr <= '0;
            r_sel  <= '0;
        end else if (clr_i) begin
            r_addr <= '0;
            r_sel  <= '0;
        end else if (en_i) begin
            if (r_addr == ADDR_MAX) begin
                r_addr <= '0;
                r_sel  <= r_sel + 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign addr_o = r_addr;
    assign sel_o  = r_sel;
    assign last_o = (r_sel == BN_OFFSET) && (r_addr == ADDR_MAX);

endmodule

// File: rtl/bn_param_loader.sv
// Streams mean/var/scale/offset words into the BN parameter RAMs and holds the
// layer idle until loaded. Define BN_LOADER_CHECKSUM_EN for an XOR trailer check.
module bn_param_loader
    import bn_pkg::*;
#(
    parameter int INPUT_SIZE       = 1,
    parameter int MEM_WORD_SIZE    = 21,
    parameter int RAM_ADDRESS_BITS = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      start_i,
    input  logic                                      valid_i,
    output logic                                      ready_o,
    input  logic [MEM_WORD_SIZE-1:0]                  data_i,
    output logic                                      w_en_o,
    output logic [MEM_WORD_SIZE-1:0]                  w_data_o,
    output logic [RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] w_addr_o,
    output logic                                      layer_hold_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      err_o
);

    localparam int WADDR_BITS = RAM_SELECT_BITS + RAM_ADDRESS_BITS;

    bn_ld_state_e r_state, w_next;

    logic                        w_ready, w_acc, w_wr, w_clr, w_last;
    logic [RAM_ADDRESS_BITS-1:0] w_cnt_addr;
    logic [RAM_SELECT_BITS-1:0]  w_cnt_sel;

    logic                     r_wen, r_done, r_hold;
    logic [MEM_WORD_SIZE-1:0] r_wdata;
    logic [WADDR_BITS-1:0]    r_waddr;

    bn_addr_counter #(
        .INPUT_SIZE (INPUT_SIZE),
        .ADDR_BITS  (RAM_ADDRESS_BITS)
    ) u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_wr),
        .clr_i   (w_clr),
        .addr_o  (w_cnt_addr),
        .sel_o   (w_cnt_sel),
        .last_o  (w_last)
    );

    // Ready decodes the state register, so it drops the cycle the FSM leaves LOAD/CHECK.
    assign w_ready = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_acc   = valid_i && w_ready;
    assign w_wr    = w_acc && (r_state == ST_LOAD);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_next = ST_LOAD;
                    w_clr  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_acc && w_last) begin
`ifdef BN_LOADER_CHECKSUM_EN
                    w_next = ST_CHECK;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
                if (w_acc) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_waddr <= '0;
        end else begin
            r_wen <= w_wr;
            if (w_wr) begin
                r_wdata <= data_i;
                r_waddr <= WADDR_BITS'(bn_pack_addr(w_cnt_sel, 30'(w_cnt_addr), RAM_ADDRESS_BITS));
            end
        end
    end

    // Done only after a full cycle in DONE, i.e. the cycle after the final strobe.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_done <= 1'b0;
            r_hold <= 1'b1;
        end else begin
            r_done <= (r_state == ST_DONE) && (w_next == ST_DONE);
            r_hold <= !((r_state == ST_DONE) && (w_next == ST_DONE));
        end
    end

`ifdef BN_LOADER_CHECKSUM_EN
    logic [MEM_WORD_SIZE-1:0] r_xor;
    logic                     r_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_clr) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_wr) begin
            r_xor <= r_xor ^ data_i;
        end else if (w_acc && (r_state == ST_CHECK)) begin
            r_err <= (data_i != r_xor);
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o      = w_ready;
    assign busy_o       = w_ready;
    assign done_o       = r_done;
    assign layer_hold_o = r_hold;
    assign w_en_o       = r_wen;
    assign w_data_o     = r_wdata;
    assign w_addr_o     = r_waddr;

endmodule

// File: tb/tb_bn_param_loader.sv
// Randomized bench for bn_param_loader against a word-count reference model;
// exercises the trailer check when BN_LOADER_CHECKSUM_EN is defined.
module tb_bn_param_loader;

    localparam int N  = 3;
    localparam int W  = 21;
    localparam int AB = 2;
    localparam int AW = 2 + AB;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_CHECK = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst, start, valid;
    logic [W-1:0]  data;
    logic          ready, wen, hold, busy, done, err;
    logic [W-1:0]  wdata;
    logic [AW-1:0] waddr;

    bn_param_loader #(.INPUT_SIZE(N), .MEM_WORD_SIZE(W)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start),
        .valid_i      (valid),
        .ready_o      (ready),
        .data_i       (data),
        .w_en_o       (wen),
        .w_data_o     (wdata),
        .w_addr_o     (waddr),
        .layer_hold_o (hold),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: load phase, words accepted so far, running XOR, expected outputs.
    int           ph;
    int           cnt;
    logic [W-1:0] mx;
    logic         e_wen, e_done, e_hold, e_err;
    logic [31:0]  e_waddr;
    logic [W-1:0] e_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; cnt = 0; mx = '0;
        e_wen = 1'b0; e_done = 1'b0; e_hold = 1'b1; e_err = 1'b0;
        e_waddr = '0; e_wdata = '0;
    endtask

    task automatic check_outs();
        logic act;
        act = (ph == P_LOAD) || (ph == P_CHECK);
        chk("ready", 32'(ready), 32'(act));
        chk("busy",  32'(busy),  32'(act));
        chk("w_en",  32'(wen),   32'(e_wen));
        chk("w_addr", 32'(waddr), e_waddr);
        chk("w_data", 32'(wdata), 32'(e_wdata));
        chk("done",  32'(done),  32'(e_done));
        chk("hold",  32'(hold),  32'(e_hold));
        chk("err",   32'(err),   32'(e_err));
    endtask

    // One clock: drive at negedge, advance model, check after the next negedge.
    task automatic cycle(input logic s, input logic v, input logic [W-1:0] d);
        logic acc, was_done;
        int   nph;
        start = s; valid = v; data = d;
        acc      = v && ((ph == P_LOAD) || (ph == P_CHECK));
        was_done = (ph == P_DONE);
        nph      = ph;
        e_wen    = 1'b0;
        case (ph)
            P_IDLE, P_DONE: if (s) begin
                nph = P_LOAD; cnt = 0; mx = '0; e_err = 1'b0;
            end
            P_LOAD: if (acc) begin
                e_wen   = 1'b1;
                e_waddr = 32'((cnt / N) * (1 << AB) + (cnt % N));
                e_wdata = d;
                mx      = mx ^ d;
                cnt++;
                if (cnt == 4 * N) begin
`ifdef BN_LOADER_CHECKSUM_EN
                    nph = P_CHECK;
`else
                    nph = P_DONE;
`endif
                end
            end
            P_CHECK: if (acc) begin
                e_err = (d != mx);
                nph   = P_DONE;
            end
            default: ;
        endcase
        e_done = was_done && (nph == P_DONE);
        e_hold = !e_done;
        ph     = nph;
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    // Fixed 1..12 stream; gap_mode inserts two idle cycles between words.
    task automatic fixed_load(input bit gap_mode, input logic [W-1:0] trailer);
        cycle(1'b1, 1'b0, '0);
        for (int k = 1; k <= 4 * N; k++) begin
            if (k == 6) cycle(1'b1, 1'b1, W'(k));
            else        cycle(1'b0, 1'b1, W'(k));
            if (gap_mode && k < 4 * N) begin
                cycle(1'b0, 1'b0, 21'h1ABCD);
                cycle(1'b0, 1'b0, 21'h1ABCD);
            end
        end
`ifdef BN_LOADER_CHECKSUM_EN
        cycle(1'b0, 1'b1, trailer);
`else
        if (trailer != '0) cycle(1'b0, 1'b0, '0);
`endif
        cycle(1'b0, 1'b1, 21'h1FFFF);
        cycle(1'b0, 1'b0, '0);
        chk("done_after_load", 32'(done), 32'd1);
    endtask

    task automatic random_load();
        int n;
        n = 0;
        cycle(1'b1, 1'b0, '0);
        while (ph != P_DONE && n < 400) begin
            if (ph == P_CHECK)
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? mx : (mx ^ W'($urandom_range(1, 7))));
            else
                cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), W'($urandom));
            n++;
        end
        if (n >= 400) begin
            checks++; errs++;
            $display("FAIL rand_load_timeout: got %0d cycles expected under 400", n);
        end
        cycle(1'b0, 1'b1, W'($urandom));
        cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outs();
        rst = 1'b0;
        cycle(1'b0, 1'b1, 21'h00055);
        cycle(1'b0, 1'b0, '0);

        fixed_load(1'b0, 21'h0000C);
        fixed_load(1'b1, 21'h0000D);
        for (int r = 0; r < 4; r++) random_load();

        // Asynchronous reset after five accepted words.
        cycle(1'b1, 1'b0, '0);
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b1, W'(k + 32));
        #2 rst = 1'b1;
        #1 model_reset();
        check_outs();
        @(negedge clk);
        rst = 1'b0;
        check_outs();
        cycle(1'b0, 1'b1, 21'h00077);
        fixed_load(1'b0, 21'h0000C);
        random_load();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
